// File: rtl/nonrestoring_divider_if.sv
// rtl/nonrestoring_divider_if.sv - start/busy/done handshake and operand/result bundle for the divider
//
// Purpose: groups the request, operand and result signals of nonrestoring_divider.
// Signals:
//   start        request from master, sampled by the divider only in IDLE
//   dividend     numerator, WIDTH bits
//   divisor      denominator, WIDTH bits
//   busy         divider is working on an accepted operation
//   done         one-cycle pulse, results valid from this cycle on
//   quotient     registered result
//   remainder    registered result
//   div_by_zero  registered flag, updated with done
// Modports: master drives start/operands, slave (the divider) drives results.
interface nonrestoring_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/nonrestoring_divider.sv
// rtl/nonrestoring_divider.sv - sequential non-restoring integer divider, one add/sub step per clock
//
// Purpose: divides dividend by divisor, WIDTH add/sub steps on a WIDTH+1-bit
//   partial remainder, followed by one remainder-correction step.
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    nonrestoring_divider_if.slave (start/dividend/divisor in,
//          busy/done/quotient/remainder/div_by_zero out)
// Parameters:
//   WIDTH  operand width, >= 2
// Configuration macro:
//   DIVIDER_SIGNED_EN  two's complement operands/results (magnitude core plus
//                      sign fix-up at DONE); undefined builds unsigned only.
module nonrestoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nonrestoring_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state, state_nx;
  logic             accept;

  logic [WIDTH:0]   a_r;        // partial remainder, a_r[WIDTH] is its sign
  logic [WIDTH-1:0] q_r;        // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] d_r;
  logic [CW-1:0]    cnt_r;
  logic             dz_r;

  logic             busy_r, done_r, div_by_zero_r;
  logic [WIDTH-1:0] quotient_r, remainder_r;

  logic [WIDTH:0]   d_ext, shifted, a_step, a_fix;
  logic [WIDTH-1:0] q_cap, q_res, r_res;

`ifdef DIVIDER_SIGNED_EN
  logic sign_n_r, sign_d_r;
  logic [WIDTH-1:0] mag_n, mag_d;
  // Magnitude of the most-negative value is 2^(WIDTH-1), which still fits
  // unsigned in WIDTH bits, so the unsigned core handles it unchanged.
  assign mag_n = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign mag_d = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
`endif

  // Next-state and accept decode.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          accept   = 1'b1;
          state_nx = (bus.divisor == '0) ? DONE : RUN;
        end
      end
      RUN:     if (cnt_r == CW'(1)) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // One non-restoring step: shift {A,Q} left, then subtract D while A is
  // non-negative, add it back while A is negative.
  assign d_ext   = {1'b0, d_r};
  assign shifted = {a_r[WIDTH-1:0], q_r[WIDTH-1]};
  assign a_step  = a_r[WIDTH] ? (shifted + d_ext) : (shifted - d_ext);
  assign a_fix   = a_r + d_ext;

  // On divide-by-zero Q keeps the raw dividend so it can be reported as the
  // remainder without extra storage.
`ifdef DIVIDER_SIGNED_EN
  assign q_cap = (bus.divisor == '0) ? bus.dividend : mag_n;
  assign q_res = dz_r ? '1   : ((sign_n_r ^ sign_d_r) ? -q_r : q_r);
  assign r_res = dz_r ? q_r  : (sign_n_r ? -a_r[WIDTH-1:0] : a_r[WIDTH-1:0]);
`else
  assign q_cap = bus.dividend;
  assign q_res = dz_r ? '1  : q_r;
  assign r_res = dz_r ? q_r : a_r[WIDTH-1:0];
`endif

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r           <= '0;
      q_r           <= '0;
      d_r           <= '0;
      cnt_r         <= '0;
      dz_r          <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      quotient_r    <= '0;
      remainder_r   <= '0;
      div_by_zero_r <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      sign_n_r      <= 1'b0;
      sign_d_r      <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_r    <= '0;
            q_r    <= q_cap;
`ifdef DIVIDER_SIGNED_EN
            d_r      <= mag_d;
            sign_n_r <= bus.dividend[WIDTH-1];
            sign_d_r <= bus.divisor[WIDTH-1];
`else
            d_r    <= bus.divisor;
`endif
            cnt_r  <= CW'(WIDTH);
            dz_r   <= (bus.divisor == '0);
            busy_r <= 1'b1;
          end
        end
        RUN: begin
          a_r   <= a_step;
          q_r   <= {q_r[WIDTH-2:0], ~a_step[WIDTH]};
          cnt_r <= cnt_r - CW'(1);
        end
        FIX: begin
          if (a_r[WIDTH]) a_r <= a_fix;
        end
        DONE: begin
          quotient_r    <= q_res;
          remainder_r   <= r_res;
          div_by_zero_r <= dz_r;
          done_r        <= 1'b1;
          busy_r        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = div_by_zero_r;
endmodule
